// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes,
// FSM states and the alignment rule.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Size 2'b11 is illegal and is reported the same way as a misaligned access.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = lo[0];
      SZ_WORD: err = (lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// DEPTH x 32 word array with per-byte write enables, synchronous write and
// asynchronous read. Contents start at zero and are not touched by reset.
module dmem_byte_ram #(
  parameter int DEPTH = 4096,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic [IW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_memory_lsu.sv
// Serialised load/store unit in front of a byte-enabled word RAM.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is high only in IDLE.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int         IW       = $clog2(DEPTH);
  localparam bit         NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [3:0] LAST_CNT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  dmem_state_e       state_q;
  logic [3:0]        cnt_q;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic              accept, resp_go, cur_err;
  logic              cur_we, cur_uns;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata, ram_rdata, lane_word, load_val;
  logic [ADDR_W-1:0] unused_addr_bits;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = !req_ready;
  assign accept    = req_valid && req_ready;
  assign dbg_state = state_q;

  // With no wait states the RAM access happens on the accept edge itself,
  // so the live request fields are used instead of the captured copy.
  assign cur_we    = NO_WAIT ? req_we       : we_q;
  assign cur_uns   = NO_WAIT ? req_unsigned : uns_q;
  assign cur_size  = NO_WAIT ? req_size     : size_q;
  assign cur_addr  = NO_WAIT ? req_addr     : addr_q;
  assign cur_wdata = NO_WAIT ? req_wdata    : wdata_q;
  assign unused_addr_bits = cur_addr;

  assign resp_go = NO_WAIT ? accept : (state_q == ST_WAIT && cnt_q == LAST_CNT);
  assign cur_err = access_error(cur_size, cur_addr[1:0]);

  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = cur_wdata;
    case (cur_size)
      SZ_BYTE: begin
        ram_be    = 4'b0001 << cur_addr[1:0];
        ram_wdata = {4{cur_wdata[7:0]}};
      end
      SZ_HALF: begin
        ram_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{cur_wdata[15:0]}};
      end
      SZ_WORD: ram_be = 4'b1111;
      default: ram_be = 4'b0000;
    endcase
    if (!resp_go || rst || !cur_we || cur_err) ram_be = 4'b0000;
  end

  dmem_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_be),
    .addr_i  (cur_addr[IW+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    lane_word = ram_rdata >> {cur_addr[1:0], 3'b000};
    load_val  = 32'd0;
    case (cur_size)
      SZ_BYTE: load_val = cur_uns ? {24'd0, lane_word[7:0]}
                                  : {{24{lane_word[7]}}, lane_word[7:0]};
      SZ_HALF: load_val = cur_uns ? {16'd0, lane_word[15:0]}
                                  : {{16{lane_word[15]}}, lane_word[15:0]};
      SZ_WORD: load_val = ram_rdata;
      default: load_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          size_q  <= req_size;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          cnt_q   <= 4'd0;
          state_q <= NO_WAIT ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == LAST_CNT) state_q <= ST_RESP;
          else cnt_q <= cnt_q + 4'd1;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      if (resp_go) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= cur_err;
        rsp_rdata_q <= (cur_err || cur_we) ? 32'd0 : load_val;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: a default instance (WAIT_STATES=1) and
// a zero-wait, 16-word instance for the wrap and single-cycle latency cases.
module tb_data_memory_lsu;
  import dmem_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid_a, req_valid_b;
  logic        req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;

  logic        ready_a, rsp_valid_a, rsp_err_a, busy_a;
  logic [31:0] rdata_a;
  logic [1:0]  state_a;
  logic        ready_b, rsp_valid_b, rsp_err_b, busy_b;
  logic [31:0] rdata_b;
  logic [1:0]  state_b;

  int n_assert = 0;
  int n_fail   = 0;

  data_memory_lsu u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(ready_a),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_a),
    .rsp_rdata(rdata_a), .rsp_err(rsp_err_a), .busy(busy_a), .dbg_state(state_a)
  );

  data_memory_lsu #(.DEPTH(16), .WAIT_STATES(0), .ADDR_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(ready_b),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr[7:0]), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rdata_b), .rsp_err(rsp_err_b), .busy(busy_b), .dbg_state(state_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // driver: issue one request, wait (bounded) for its response
  task automatic do_req(input bit sel, input logic we, input logic [1:0] size,
                        input logic uns, input logic [13:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    chk("ready_before_req", sel ? ready_b : ready_a, 1);
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    lat = 1;
    while (lat <= 20 && !(sel ? rsp_valid_b : rsp_valid_a)) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = sel ? rdata_b : rdata_a;
    err   = sel ? rsp_err_b : rsp_err_a;
    @(posedge clk); #1;
    chk("rsp_single_pulse", sel ? rsp_valid_b : rsp_valid_a, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          acc_cnt, pulse_cnt;

  initial begin
    rst = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid_a, 0);
    chk("rst_rsp_err",   rsp_err_a, 0);
    chk("rst_rsp_rdata", rdata_a, 0);
    chk("rst_state",     state_a, 32'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", ready_a, 1);
    chk("post_rst_busy",  busy_a, 0);

    // word store / load with WAIT_STATES = 1
    do_req(0, 1, SZ_WORD, 0, 14'h28, 32'hDEADBEEF, rd, er, lat);
    chk("st_w_lat", 32'(lat), 2);
    chk("st_w_err", er, 0);
    chk("st_w_rdata", rd, 0);
    do_req(0, 0, SZ_WORD, 0, 14'h28, 32'h0, rd, er, lat);
    chk("ld_w_lat", 32'(lat), 2);
    chk("ld_w_err", er, 0);
    chk("ld_w_rdata", rd, 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    #1;
    chk("rdata_hold", rdata_a, 32'hDEADBEEF);

    // byte store steering and extension
    do_req(0, 1, SZ_BYTE, 0, 14'h29, 32'hABCDEF80, rd, er, lat);
    chk("st_b_err", er, 0);
    do_req(0, 0, SZ_BYTE, 0, 14'h29, 32'h0, rd, er, lat);
    chk("ld_b_signed", rd, 32'hFFFFFF80);
    do_req(0, 0, SZ_BYTE, 1, 14'h29, 32'h0, rd, er, lat);
    chk("ld_b_unsigned", rd, 32'h00000080);
    do_req(0, 0, SZ_WORD, 1, 14'h28, 32'h0, rd, er, lat);
    chk("ld_w_after_b", rd, 32'hDEAD80EF);
    do_req(0, 0, SZ_HALF, 0, 14'h2A, 32'h0, rd, er, lat);
    chk("ld_h_signed", rd, 32'hFFFFDEAD);
    do_req(0, 0, SZ_HALF, 1, 14'h28, 32'h0, rd, er, lat);
    chk("ld_h_unsigned", rd, 32'h000080EF);
    do_req(0, 0, SZ_BYTE, 0, 14'h28, 32'h0, rd, er, lat);
    chk("ld_b0_signed", rd, 32'hFFFFFFEF);

    // errors
    do_req(0, 0, SZ_HALF, 0, 14'h2B, 32'h0, rd, er, lat);
    chk("ld_h_mis_err", er, 1);
    chk("ld_h_mis_rdata", rd, 0);
    do_req(0, 1, SZ_WORD, 0, 14'h2A, 32'hFFFFFFFF, rd, er, lat);
    chk("st_w_mis_err", er, 1);
    do_req(0, 0, SZ_WORD, 0, 14'h28, 32'h0, rd, er, lat);
    chk("mem_unchanged", rd, 32'hDEAD80EF);
    chk("mem_unchanged_err", er, 0);
    do_req(0, 0, 2'b11, 0, 14'h28, 32'h0, rd, er, lat);
    chk("size11_err", er, 1);
    chk("size11_rdata", rd, 0);

    // back-to-back: req_valid held high for three full transactions
    req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 14'h28;
    req_valid_a = 1'b1;
    acc_cnt = 0; pulse_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      chk("b2b_ready", ready_a, (i % 3 == 0) ? 1 : 0);
      chk("b2b_busy", busy_a, (i % 3 == 0) ? 0 : 1);
      chk("b2b_rsp_valid", rsp_valid_a, (i % 3 == 2) ? 1 : 0);
      if (ready_a) acc_cnt++;
      if (rsp_valid_a) begin
        pulse_cnt++;
        chk("b2b_rdata", rdata_a, 32'hDEAD80EF);
      end
      @(posedge clk); #1;
    end
    req_valid_a = 1'b0;
    chk("b2b_accepts", 32'(acc_cnt), 3);
    chk("b2b_pulses", 32'(pulse_cnt), 3);

    // reset during WAIT aborts the store
    req_we = 1'b1; req_size = SZ_WORD; req_addr = 14'h40; req_wdata = 32'h12345678;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    chk("abort_in_wait", state_a, 32'(ST_WAIT));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_rsp_valid", rsp_valid_a, 0);
    chk("abort_state", state_a, 32'(ST_IDLE));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", rsp_valid_a, 0);
    end
    do_req(0, 0, SZ_WORD, 0, 14'h40, 32'h0, rd, er, lat);
    chk("abort_no_write", rd, 0);

    // zero-wait, 16-word instance: wrap and single-cycle latency
    do_req(1, 1, SZ_WORD, 0, 14'h40, 32'hCAFEF00D, rd, er, lat);
    chk("nw_st_lat", 32'(lat), 1);
    chk("nw_st_err", er, 0);
    do_req(1, 0, SZ_WORD, 0, 14'h00, 32'h0, rd, er, lat);
    chk("nw_ld_lat", 32'(lat), 1);
    chk("nw_ld_wrap", rd, 32'hCAFEF00D);
    do_req(1, 0, SZ_BYTE, 1, 14'h03, 32'h0, rd, er, lat);
    chk("nw_ld_b_unsigned", rd, 32'h000000CA);
    do_req(1, 0, SZ_BYTE, 0, 14'h03, 32'h0, rd, er, lat);
    chk("nw_ld_b_signed", rd, 32'hFFFFFFCA);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
DATA_MEMORY_LSU -- requirements
Module: data_memory_lsu

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4096, meaning the number of 32-bit words, a power of two.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, range 0..15, meaning the extra cycles between request acceptance and response.
REQ-003 The block SHALL have parameter ADDR_W, default $clog2(DEPTH)+2, meaning the byte-address width.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port req_valid, input, 1 bit: request present.
REQ-008 Port req_ready, output, 1 bit: block can accept a request.
REQ-009 Port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-010 Port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-011 Port req_unsigned, input, 1 bit: zero-extend the load result when 1, sign-extend when 0.
REQ-012 Port req_addr, input, ADDR_W bits: little-endian byte address.
REQ-013 Port req_wdata, input, 32 bits: store data, right-aligned.
REQ-014 Port rsp_valid, output, 1 bit: one-cycle pulse marking a completed request.
REQ-015 Port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-016 Port rsp_err, output, 1 bit: misaligned or illegal-size request, qualified by rsp_valid.
REQ-017 Port busy, output, 1 bit: equals !req_ready; pipeline stall source.

Function
REQ-018 The FSM SHALL have three states: IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted when req_valid && req_ready; all request fields SHALL be captured into internal registers in that same cycle.
REQ-020 Transitions SHALL be:
- IDLE -> WAIT on accept when WAIT_STATES > 0, otherwise IDLE -> RESP.
- WAIT -> RESP when the wait counter reaches WAIT_STATES-1.
- RESP -> IDLE unconditionally.
REQ-021 rsp_valid SHALL be asserted exactly in RESP, so acceptance in cycle N gives rsp_valid in cycle N+1+WAIT_STATES.
REQ-022 Misalignment SHALL be detected as: half with addr[0] = 1, or word with addr[1:0] != 0; size 11 SHALL also be an error.
REQ-023 An erroring request SHALL not modify memory and SHALL return rsp_rdata = 0 with rsp_err = 1.
REQ-024 A store SHALL write memory at the RESP-entry edge using byte lanes:
- byte: lane addr[1:0] <= wdata[7:0].
- half: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0].
- word: all lanes.
REQ-025 A load SHALL read the word at addr[ADDR_W-1:2], select the lane(s) by addr[1:0], and extend per req_unsigned; a word load SHALL ignore req_unsigned.
REQ-026 Address bits above the DEPTH range SHALL wrap (modulo DEPTH words).
REQ-027 A load following a store to the same address SHALL return the stored data, with no forwarding hazard, because accesses are serialised.
REQ-028 rsp_rdata SHALL be registered and SHALL hold its value until the next RESP.
REQ-029 Memory SHALL be initialised to all zeros at time zero.

Reset
REQ-030 While rst is 1 at a clock edge, the state SHALL go to IDLE, the wait counter to 0, and rsp_valid, rsp_err and rsp_rdata to 0.
REQ-031 Reset SHALL take priority over acceptance.
REQ-032 Reset asserted in WAIT or RESP SHALL abort the in-flight request with no memory write and no rsp_valid.
REQ-033 Memory contents SHALL be unaffected by reset.
REQ-034 req_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-035 The size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum SHALL live in the shared package dmem_pkg.
REQ-036 The block SHALL contain one sub-module, dmem_byte_ram: a DEPTH x 32 array with a 4-bit byte-write-enable, synchronous write and asynchronous read.
REQ-037 Alignment checking, lane steering and extension SHALL remain in data_memory_lsu.

Verification
REQ-038 Reset then store word 0xDEADBEEF at address 0x28, then load word at 0x28 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid 2 cycles after acceptance (WAIT_STATES = 1).
REQ-039 Store byte 0x80 at 0x29, then load byte signed at 0x29 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word at 0x28 -> 0xDEAD80EF.
REQ-040 Load half at 0x2B -> rsp_err = 1, rsp_rdata = 0; store word at 0x2A -> rsp_err = 1 and memory at 0x28 is unchanged.
REQ-041 Hold req_valid high with back-to-back requests -> req_ready is low during WAIT and RESP, each request is accepted exactly once, and there are no lost or duplicated rsp_valid pulses.
REQ-042 Assert rst during WAIT of a store of 0x12345678 to 0x40 -> no rsp_valid and a later load at 0x40 returns 0.
REQ-043 With WAIT_STATES = 0 and DEPTH = 16, store at byte address 0x40 then load at 0x00 -> data matches (wrap), with latency 1 cycle.
